// File: rtl/spi_integrator_ctrl.sv
// spi_integrator_ctrl: SPI sequencer for the dual-slope integrator
// switches (reset/in/ref) with dead time, a conversion counter and readback.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   sck, ssel, mosi   SPI mode 0 slave inputs (async to clk)
//   miso              SPI data out, 0 while ssel is high
//   m_reset           1 = integrate, 0 = cap shorted
//   m_in, m_ref       input / reference switch enables
module spi_integrator_ctrl #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEADTIME    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic ssel,
  input  logic mosi,
  output logic miso,
  output logic m_reset,
  output logic m_in,
  output logic m_ref
);

  localparam int FW = 8 + DATA_W;
  localparam int BW = $clog2(FW + 1);
  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [BW-1:0] FULL = BW'(FW);
  localparam logic [BW-1:0] LAST = BW'(FW - 1);
  localparam logic [DW-1:0] DT_LOAD = DW'(DEADTIME);
  localparam logic [DW-1:0] DT_ONE = DW'(1);

  logic [SYNC_STAGES-1:0] sck_sq, ssel_sq, mosi_sq;
  logic sck_hq, ssel_hq;
  logic sck_s, ssel_s, mosi_s;
  logic sck_rise, sck_fall, ssel_fall, act;

  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [FW-1:0] sh_q, sh_d;
  logic [FW-1:0] tx_q, tx_d;
  logic exec_q, exec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dt_q, dt_d;
  logic sel_q, sel_d;
  logic gate_q, gate_d;
  logic err_q, err_d;
  logic mrst_q, mrst_d;
  logic min_q, min_d;
  logic mref_q, mref_d;

  logic [7:0] cmd;
  logic [7:0] status;
  logic sel_nx, clr, inc;

  assign sck_s  = sck_sq[SYNC_STAGES-1];
  assign ssel_s = ssel_sq[SYNC_STAGES-1];
  assign mosi_s = mosi_sq[SYNC_STAGES-1];

  assign sck_rise  = sck_s & ~sck_hq;
  assign sck_fall  = ~sck_s & sck_hq;
  assign ssel_fall = ~ssel_s & ssel_hq;
  assign act       = ~ssel_s;

  assign cmd    = sh_q[FW-1 -: 8];
  assign status = {err_q, gate_q, mrst_q, min_q, 4'b1010};
  assign inc    = ~gate_q | mrst_q;

  // Gate on the raw pin so miso drops as soon as the master deselects.
  assign miso    = ~ssel & tx_q[FW-1];
  assign m_reset = mrst_q;
  assign m_in    = min_q;
  assign m_ref   = mref_q;

  always_comb begin
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    exec_d   = 1'b0;
    if (!act) begin
      bitcnt_d = '0;
    end else if (sck_rise && bitcnt_q != FULL) begin
      sh_d     = {sh_q[FW-2:0], mosi_s};
      bitcnt_d = bitcnt_q + 1'b1;
      exec_d   = (bitcnt_q == LAST);
    end

    tx_d = tx_q;
    if (ssel_fall) begin
      tx_d = {status, cnt_q[DATA_W-1:0]};
    end else if (act && sck_fall) begin
      tx_d = {tx_q[FW-2:0], 1'b0};
    end

    mrst_d = mrst_q;
    gate_d = gate_q;
    err_d  = err_q;
    sel_nx = sel_q;
    clr    = 1'b0;
    if (exec_q) begin
      unique case (1'b1)
        cmd == 8'h01: begin
          mrst_d = sh_q[0];
          sel_nx = sh_q[1];
        end
        cmd == 8'h02: begin
          clr   = 1'b1;
          err_d = 1'b0;
        end
        cmd == 8'h03: gate_d = sh_q[0];
        cmd == 8'h04: begin
        end
        default: err_d = 1'b1;
      endcase
    end

    // Clear wins over a same-cycle increment.
    cnt_d = clr ? '0
                : cnt_q + {{(CNT_W-1){1'b0}}, inc};

    sel_d  = sel_q;
    dt_d   = dt_q;
    min_d  = min_q;
    mref_d = mref_q;
    if (sel_nx != sel_q) begin
      // Break before make; a change mid dead time restarts it.
      sel_d  = sel_nx;
      dt_d   = DT_LOAD;
      min_d  = 1'b0;
      mref_d = 1'b0;
    end else if (dt_q != '0) begin
      dt_d = dt_q - DT_ONE;
      if (dt_q == DT_ONE) begin
        min_d  = sel_q;
        mref_d = ~sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sq   <= '0;
      ssel_sq  <= '1;
      mosi_sq  <= '0;
      sck_hq   <= 1'b0;
      ssel_hq  <= 1'b1;
      bitcnt_q <= '0;
      sh_q     <= '0;
      tx_q     <= '0;
      exec_q   <= 1'b0;
      cnt_q    <= '0;
      // Dead time runs out of reset so m_ref comes up late.
      dt_q     <= DT_LOAD;
      sel_q    <= 1'b0;
      gate_q   <= 1'b0;
      err_q    <= 1'b0;
      mrst_q   <= 1'b0;
      min_q    <= 1'b0;
      mref_q   <= 1'b0;
    end else begin
      sck_sq   <= {sck_sq[SYNC_STAGES-2:0], sck};
      ssel_sq  <= {ssel_sq[SYNC_STAGES-2:0], ssel};
      mosi_sq  <= {mosi_sq[SYNC_STAGES-2:0], mosi};
      sck_hq   <= sck_s;
      ssel_hq  <= ssel_s;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      exec_q   <= exec_d;
      cnt_q    <= cnt_d;
      dt_q     <= dt_d;
      sel_q    <= sel_d;
      gate_q   <= gate_d;
      err_q    <= err_d;
      mrst_q   <= mrst_d;
      min_q    <= min_d;
      mref_q   <= mref_d;
    end
  end

endmodule

// File: tb/tb_spi_integrator_ctrl.sv
// tb_spi_integrator_ctrl: directed bench for spi_integrator_ctrl
// (32-bit instance plus an 8-bit instance for counter wrap).
module tb_spi_integrator_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic sck_d = 1'b0, ssel_d = 1'b1, mosi_d = 1'b0;
  logic tgt = 1'b0;

  logic sck0, ssel0, mosi0, miso0, mr0, mi0, mf0;
  logic sck8, ssel8, mosi8, miso8, mr8, mi8, mf8;
  logic miso_s;

  assign sck0  = tgt ? 1'b0 : sck_d;
  assign ssel0 = tgt ? 1'b1 : ssel_d;
  assign mosi0 = tgt ? 1'b0 : mosi_d;
  assign sck8  = tgt ? sck_d : 1'b0;
  assign ssel8 = tgt ? ssel_d : 1'b1;
  assign mosi8 = tgt ? mosi_d : 1'b0;
  assign miso_s = tgt ? miso8 : miso0;

  spi_integrator_ctrl #(
    .DATA_W(32), .CNT_W(32), .SYNC_STAGES(2), .DEADTIME(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sck(sck0), .ssel(ssel0),
    .mosi(mosi0), .miso(miso0), .m_reset(mr0),
    .m_in(mi0), .m_ref(mf0)
  );

  spi_integrator_ctrl #(
    .DATA_W(8), .CNT_W(8), .SYNC_STAGES(2), .DEADTIME(4)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sck(sck8), .ssel(ssel8),
    .mosi(mosi8), .miso(miso8), .m_reset(mr8),
    .m_in(mi8), .m_ref(mf8)
  );

  int checks = 0;
  int errors = 0;

  // Switch monitor on the 32-bit instance.
  int run = 0, last_run = 0, runs = 0, both_hi = 0;
  always @(negedge clk) begin
    if (mi0 && mf0) both_hi++;
    if (!mi0 && !mf0) run++;
    else if (run != 0) begin
      last_run = run;
      runs++;
      run = 0;
    end
  end

  int t_fall, t_last, t_rel;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi_d = b;
    tick(4);
    m = miso_s;
    sck_d = 1'b1;
    t_last = cyc;
    tick(4);
    sck_d = 1'b0;
  endtask

  task automatic spi_xfer(input int nbits, input logic [39:0] din,
                          input int nsend, output logic [39:0] dout);
    logic m;
    dout = '0;
    ssel_d = 1'b0;
    t_fall = cyc;
    for (int i = 0; i < nsend; i++) begin
      spi_bit(din[nbits-1-i], m);
      dout = {dout[38:0], m};
    end
    tick(4);
    ssel_d = 1'b1;
    mosi_d = 1'b0;
    tick(12);
  endtask

  task automatic chk(input string nm, input logic [39:0] got,
                     input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic test_reset;
    logic [39:0] d;
    tick(3);
    rst_n = 1'b1;
    t_rel = cyc;
    checks++;
    if (mf0 !== 1'b0 || mi0 !== 1'b0 || mr0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_out got %b%b%b exp 000", mr0, mi0, mf0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (mf0 !== 1'b0) begin
        errors++;
        $display("FAIL rst_dead%0d got %b exp 0", i, mf0);
      end
    end
    tick(1);
    checks++;
    if (mf0 !== 1'b1 || mi0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_ref got %b%b exp 01", mi0, mf0);
    end
    checks++;
    if (miso0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_miso got %b exp 0", miso0);
    end
    spi_xfer(40, {8'h04, 32'h0}, 40, d);
    checks++;
    if (d[39:32] !== 8'h0A) begin
      errors++;
      $display("FAIL rst_status got %h exp 0a", d[39:32]);
    end
    checks++;
    if (d[31:0] !== 32'(t_fall + 2 - t_rel)) begin
      errors++;
      $display("FAIL rst_count got %0d exp %0d", d[31:0],
               t_fall + 2 - t_rel);
    end
  endtask

  task automatic test_wr_ctrl;
    logic [39:0] d;
    int r0;
    r0 = runs;
    spi_xfer(40, {8'h01, 32'd3}, 40, d);
    tick(4);
    checks++;
    if (mr0 !== 1'b1 || mi0 !== 1'b1 || mf0 !== 1'b0) begin
      errors++;
      $display("FAIL wr_out got %b%b%b exp 110", mr0, mi0, mf0);
    end
    checks++;
    if (runs !== r0 + 1 || last_run !== 4) begin
      errors++;
      $display("FAIL wr_dead got runs %0d len %0d exp %0d len 4",
               runs - r0, last_run, 1);
    end
    r0 = runs;
    spi_xfer(40, {8'h01, 32'd3}, 40, d);
    tick(4);
    checks++;
    if (runs !== r0 || mi0 !== 1'b1) begin
      errors++;
      $display("FAIL wr_same got runs %0d m_in %b exp 0 1",
               runs - r0, mi0);
    end
    spi_xfer(40, {8'h04, 32'h0}, 40, d);
    chk("wr_status", {32'h0, d[39:32]}, 40'h3A);
  endtask

  task automatic test_gate;
    logic [39:0] d;
    logic [31:0] a, b, df;
    int ts;
    spi_xfer(40, {8'h01, 32'd0}, 40, d);
    spi_xfer(40, {8'h03, 32'd1}, 40, d);
    spi_xfer(40, {8'h04, 32'h0}, 40, d);
    a = d[31:0];
    chk("gate_status", {32'h0, d[39:32]}, 40'h4A);
    tick(50);
    spi_xfer(40, {8'h04, 32'h0}, 40, d);
    b = d[31:0];
    checks++;
    if (b !== a) begin
      errors++;
      $display("FAIL gate_frozen got %0d exp %0d", b, a);
    end
    ts = cyc;
    spi_xfer(40, {8'h01, 32'd1}, 40, d);
    while (cyc < ts + 1000) tick(1);
    spi_xfer(40, {8'h01, 32'd0}, 40, d);
    spi_xfer(40, {8'h04, 32'h0}, 40, d);
    df = d[31:0] - b;
    checks++;
    if (df < 999 || df > 1001) begin
      errors++;
      $display("FAIL gate_delta got %0d exp 1000", df);
    end
    spi_xfer(40, {8'h03, 32'd0}, 40, d);
  endtask

  task automatic test_short_err;
    logic [39:0] d;
    int r0, tl;
    r0 = runs;
    spi_xfer(40, {8'h01, 32'd3}, 20, d);
    tick(8);
    checks++;
    if (mr0 !== 1'b0 || mi0 !== 1'b0 || mf0 !== 1'b1 || runs !== r0) begin
      errors++;
      $display("FAIL short got %b%b%b runs %0d exp 001 runs 0",
               mr0, mi0, mf0, runs - r0);
    end
    spi_xfer(40, {8'h7F, 32'h0}, 40, d);
    spi_xfer(40, {8'h04, 32'h0}, 40, d);
    chk("err_status", {32'h0, d[39:32]}, 40'h8A);
    spi_xfer(40, {8'h02, 32'h0}, 40, d);
    tl = t_last;
    spi_xfer(40, {8'h04, 32'h0}, 40, d);
    chk("clr_status", {32'h0, d[39:32]}, 40'h0A);
    chk("clr_count", {8'h0, d[31:0]}, {8'h0, 32'(t_fall - tl - 2)});
  endtask

  task automatic test_wrap8;
    logic [39:0] d;
    int a, ta, k, tl;
    tgt = 1'b1;
    tick(2);
    spi_xfer(16, {24'h0, 8'h04, 8'h00}, 16, d);
    a = int'(d[7:0]);
    ta = t_fall;
    chk("w8_status", {32'h0, d[15:8]}, 40'h0A);
    k = 256 - a + 10;
    if (k < 200) k += 256;
    while (cyc < ta + k) tick(1);
    spi_xfer(16, {24'h0, 8'h04, 8'h00}, 16, d);
    chk("w8_wrap", {32'h0, d[7:0]}, 40'd10);
    spi_xfer(16, {24'h0, 8'h02, 8'h00}, 16, d);
    tl = t_last;
    spi_xfer(16, {24'h0, 8'h04, 8'h00}, 16, d);
    chk("w8_clr", {32'h0, d[7:0]}, {32'h0, 8'(t_fall - tl - 2)});
    tgt = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_midframe;
    logic [39:0] din, d;
    logic m;
    din = {8'h01, 32'd3};
    ssel_d = 1'b0;
    for (int i = 0; i < 12; i++) spi_bit(din[39-i], m);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    for (int i = 12; i < 40; i++) spi_bit(din[39-i], m);
    tick(4);
    ssel_d = 1'b1;
    tick(12);
    checks++;
    if (mr0 !== 1'b0 || mi0 !== 1'b0 || mf0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got %b%b%b exp 001", mr0, mi0, mf0);
    end
    spi_xfer(40, {8'h04, 32'h0}, 40, d);
    chk("mid_status", {32'h0, d[39:32]}, 40'h0A);
    spi_xfer(40, {8'h01, 32'd3}, 40, d);
    tick(4);
    checks++;
    if (mr0 !== 1'b1 || mi0 !== 1'b1 || mf0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_next got %b%b%b exp 110", mr0, mi0, mf0);
    end
    checks++;
    if (both_hi !== 0) begin
      errors++;
      $display("FAIL both_on got %0d exp 0", both_hi);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick(1);
    test_reset;
    test_wr_ctrl;
    test_gate;
    test_short_err;
    test_wrap8;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
